// File: rtl/beta_pkg.sv
// beta_pkg: shared encodings for the Beta writeback path.
//   - WDSEL_* : write-data source select (PC+4, ALU result, memory load data)
//   - R_*     : architectural register indices with special meaning
//   - wb_state_e : writeback stage FSM states
package beta_pkg;

    localparam logic [1:0] WDSEL_PC4 = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    localparam logic [4:0] R_BP   = 5'd27;
    localparam logic [4:0] R_LP   = 5'd28;
    localparam logic [4:0] R_SP   = 5'd29;
    localparam logic [4:0] R_XP   = 5'd30;
    localparam logic [4:0] R_ZERO = 5'd31;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_WAIT_LOAD = 2'd1,
        WB_WRITE     = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: compares one operand-read register against the pending
// writeback destination and produces the forwarding outcome.
// Ports:
//   stg_valid  in   stage holds an accepted instruction
//   stg_real   in   that instruction really writes the regfile
//   stg_wait   in   stage is still waiting for load data
//   stg_dest   in   pending destination (XP already substituted)
//   stg_data   in   pending write data (meaningful only when not waiting)
//   rs         in   operand register being read
//   hit        out  forward stg_data for this operand
//   stall      out  operand depends on a load that has not returned
//   data       out  forwarded value, 0 when no hit
module wb_fwd_match
    import beta_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter logic [4:0]  ZERO_REG = R_ZERO
) (
    input  logic              stg_valid,
    input  logic              stg_real,
    input  logic              stg_wait,
    input  logic [4:0]        stg_dest,
    input  logic [DATA_W-1:0] stg_data,
    input  logic [4:0]        rs,
    output logic              hit,
    output logic              stall,
    output logic [DATA_W-1:0] data
);

    logic match;

    assign match = stg_valid & stg_real & (rs == stg_dest) & (stg_dest != ZERO_REG);
    assign hit   = match & ~stg_wait;
    assign stall = match & stg_wait;
    assign data  = hit ? stg_data : '0;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: single-stage writeback driver for the Beta regfile.
// Accepts retiring instructions, selects the write data (PC+4 / ALU / load),
// waits for load data when required and pulses the regfile write port for
// one cycle. Also reports forwarding hits/stalls for the pending result.
// Optional build macro WB_STATS_EN enables the stat_* counters; without it
// the stat ports read 0.
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   in_valid/in_ready      retire handshake
//   in_rc, in_werf, in_wasel, in_wdsel, in_pc4, in_alu   retiring instruction
//   mem_rdata, mem_rvalid  load return (only looked at while waiting)
//   wdata, rc, wasel, werf regfile write port, werf is a one-cycle pulse
//   fwd_ra/fwd_rb          operand registers being read
//   fwd_*_hit/fwd_*_data   forwarded pending result
//   fwd_stall              an operand waits on an outstanding load
//   stat_writes            werf pulses since reset
//   stat_load_wait         cycles spent waiting for load data since reset
module regfile_writeback
    import beta_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter logic [4:0]  XP_REG   = R_XP,
    parameter logic [4:0]  ZERO_REG = R_ZERO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rc,
    input  logic              in_werf,
    input  logic              in_wasel,
    input  logic [1:0]        in_wdsel,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] wdata,
    output logic [4:0]        rc,
    output logic              wasel,
    output logic              werf,
    input  logic [4:0]        fwd_ra,
    input  logic [4:0]        fwd_rb,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data,
    output logic              fwd_stall,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_load_wait
);

    wb_state_e         state, state_nx;
    logic              stg_real;
    logic [4:0]        stg_dest;

    logic              accept, acc_real, acc_load, load_done;
    logic [4:0]        acc_dest;
    logic [DATA_W-1:0] acc_data;

    assign in_ready  = (state != WB_WAIT_LOAD);
    assign accept    = in_valid & in_ready;
    assign acc_dest  = in_wasel ? XP_REG : in_rc;
    // Exceptions always write XP, so R31 only suppresses non-exception writes.
    assign acc_real  = in_werf & (in_wasel | (in_rc != ZERO_REG));
    // A load to R31 still waits for its data; it just never writes.
    assign acc_load  = in_werf & ~in_wasel & (in_wdsel == WDSEL_MEM);
    assign load_done = (state == WB_WAIT_LOAD) & mem_rvalid;

    always_comb begin
        acc_data = in_alu;
        if (in_wasel || in_wdsel == WDSEL_PC4)
            acc_data = in_pc4;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WB_IDLE, WB_WRITE:
                if (accept) state_nx = acc_load ? WB_WAIT_LOAD : WB_WRITE;
                else        state_nx = WB_IDLE;
            WB_WAIT_LOAD:
                if (mem_rvalid) state_nx = WB_WRITE;
            default:
                state_nx = WB_IDLE;
        endcase
    end

    // wdata/rc/wasel only update on a real write, so they double as the
    // stage data for forwarding while in WRITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= WB_IDLE;
            stg_real <= 1'b0;
            stg_dest <= '0;
            wdata    <= '0;
            rc       <= '0;
            wasel    <= 1'b0;
            werf     <= 1'b0;
        end else begin
            state <= state_nx;
            werf  <= 1'b0;
            if (accept) begin
                stg_real <= acc_real;
                stg_dest <= acc_dest;
                if (acc_real && !acc_load) begin
                    wdata <= acc_data;
                    rc    <= acc_dest;
                    wasel <= in_wasel;
                    werf  <= 1'b1;
                end
            end else if (load_done && stg_real) begin
                wdata <= mem_rdata;
                rc    <= stg_dest;
                wasel <= 1'b0;
                werf  <= 1'b1;
            end
        end
    end

    // Forwarding: one matcher per operand read port.
    logic [1:0][4:0]        rs_v;
    logic [1:0]             hit_v, stall_v;
    logic [1:0][DATA_W-1:0] data_v;

    assign rs_v[0] = fwd_ra;
    assign rs_v[1] = fwd_rb;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        wb_fwd_match #(
            .DATA_W   (DATA_W),
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .stg_valid (state != WB_IDLE),
            .stg_real  (stg_real),
            .stg_wait  (state == WB_WAIT_LOAD),
            .stg_dest  (stg_dest),
            .stg_data  (wdata),
            .rs        (rs_v[p]),
            .hit       (hit_v[p]),
            .stall     (stall_v[p]),
            .data      (data_v[p])
        );
    end

    assign fwd_a_hit  = hit_v[0];
    assign fwd_b_hit  = hit_v[1];
    assign fwd_a_data = data_v[0];
    assign fwd_b_data = data_v[1];
    assign fwd_stall  = |stall_v;

`ifdef WB_STATS_EN
    logic [31:0] wr_cnt, wait_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt   <= '0;
            wait_cnt <= '0;
        end else begin
            if (werf)                   wr_cnt   <= wr_cnt + 32'd1;
            if (state == WB_WAIT_LOAD)  wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign stat_writes    = wr_cnt;
    assign stat_load_wait = wait_cnt;
`else
    assign stat_writes    = '0;
    assign stat_load_wait = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized scoreboard bench for regfile_writeback.
// The driver pushes each expected regfile write into a queue as it issues
// stimulus; a negedge monitor pops on every werf pulse and also checks the
// forwarding outputs against what the bench knows is pending.
module tb_regfile_writeback;

    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_werf, in_wasel;
    logic [4:0]        in_rc;
    logic [1:0]        in_wdsel;
    logic [DATA_W-1:0] in_pc4, in_alu, mem_rdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        rc;
    logic              wasel, werf;
    logic [4:0]        fwd_ra, fwd_rb;
    logic              fwd_a_hit, fwd_b_hit, fwd_stall;
    logic [DATA_W-1:0] fwd_a_data, fwd_b_data;
    logic [31:0]       stat_writes, stat_load_wait;

    regfile_writeback #(.DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rc(in_rc),
        .in_werf(in_werf), .in_wasel(in_wasel), .in_wdsel(in_wdsel),
        .in_pc4(in_pc4), .in_alu(in_alu),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wdata(wdata), .rc(rc), .wasel(wasel), .werf(werf),
        .fwd_ra(fwd_ra), .fwd_rb(fwd_rb),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .fwd_stall(fwd_stall),
        .stat_writes(stat_writes), .stat_load_wait(stat_load_wait)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  dest;
        logic        wasel;
        logic [31:0] data;
    } wr_t;

    wr_t  expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   wait_flag = 1'b0;
    logic [4:0] wait_rc = '0;
    logic [4:0] last_dest = '0;
    int   force_ra = -1;
    int   force_rb = -1;
    int   model_writes = 0;
    int   model_waits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: all DUT outputs are sampled on the negedge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (wait_flag) model_waits++;
                if (werf === 1'b1) begin
                    if (expq.size() == 0) begin
                        chk("spurious_werf", {31'd0, werf}, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        model_writes++;
                        chk("wr_rc", {27'd0, rc}, {27'd0, e.dest});
                        chk("wr_wasel", {31'd0, wasel}, {31'd0, e.wasel});
                        chk("wr_wdata", wdata, e.data);
                        chk("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, fwd_ra == e.dest});
                        chk("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, fwd_rb == e.dest});
                        chk("fwd_a_data", fwd_a_data, (fwd_ra == e.dest) ? e.data : 32'd0);
                        chk("fwd_b_data", fwd_b_data, (fwd_rb == e.dest) ? e.data : 32'd0);
                        chk("fwd_stall_wr", {31'd0, fwd_stall}, 32'd0);
                    end
                end else begin
                    chk("fwd_a_hit_none", {31'd0, fwd_a_hit}, 32'd0);
                    chk("fwd_b_hit_none", {31'd0, fwd_b_hit}, 32'd0);
                    chk("fwd_a_data_none", fwd_a_data, 32'd0);
                    chk("fwd_b_data_none", fwd_b_data, 32'd0);
                    if (wait_flag)
                        chk("fwd_stall_wait", {31'd0, fwd_stall},
                            {31'd0, (wait_rc != 5'd31) && (fwd_ra == wait_rc || fwd_rb == wait_rc)});
                    else
                        chk("fwd_stall_idle", {31'd0, fwd_stall}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pick_fwd();
        fwd_ra = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
        fwd_rb = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
        if (force_ra >= 0) fwd_ra = 5'(force_ra);
        if (force_rb >= 0) fwd_rb = 5'(force_rb);
    endtask

    // Random instruction presented while the DUT must refuse it.
    task automatic junk();
        in_valid = 1'($urandom_range(0, 1));
        in_rc    = 5'($urandom_range(0, 31));
        in_werf  = 1'b1;
        in_wasel = 1'($urandom_range(0, 1));
        in_wdsel = 2'($urandom_range(0, 2));
        in_pc4   = $urandom;
        in_alu   = $urandom;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        pick_fwd();
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
    endtask

    // Issue one instruction at posedge+1; for a load, also return its data
    // after dly extra wait cycles.
    task automatic send(input logic [4:0] r, input logic we, input logic ws,
                        input logic [1:0] sel, input logic [31:0] pc4,
                        input logic [31:0] alu, input int dly, input logic [31:0] ld);
        logic        is_load, is_real;
        logic [4:0]  dest;
        logic [31:0] d;
        dest    = ws ? 5'd30 : r;
        is_real = we && (ws || r != 5'd31);
        is_load = we && !ws && sel == 2'd2;
        d       = (ws || sel == 2'd0) ? pc4 : alu;
        in_valid = 1'b1; in_rc = r; in_werf = we; in_wasel = ws;
        in_wdsel = sel; in_pc4 = pc4; in_alu = alu;
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
        pick_fwd();
        chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
        if (is_real && !is_load) expq.push_back('{dest, ws, d});
        @(posedge clock); #1;
        in_valid = 1'b0; mem_rvalid = 1'b0;
        last_dest = dest;
        if (is_load) begin
            wait_flag = 1'b1;
            wait_rc   = r;
            for (int k = 0; k < dly; k++) begin
                junk(); pick_fwd();
                chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
                @(posedge clock); #1;
            end
            junk(); pick_fwd();
            chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = ld;
            if (is_real) expq.push_back('{r, 1'b0, ld});
            @(posedge clock); #1;
            mem_rvalid = 1'b0; in_valid = 1'b0; wait_flag = 1'b0;
        end
    endtask

    initial begin
        logic [4:0] r;
        logic       we, ws;
        logic [1:0] sel;

        reset = 1'b1; in_valid = 1'b0; in_rc = '0; in_werf = 1'b0; in_wasel = 1'b0;
        in_wdsel = '0; in_pc4 = '0; in_alu = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        fwd_ra = '0; fwd_rb = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rc", {27'd0, rc}, 32'd0);
        chk("rst_wasel", {31'd0, wasel}, 32'd0);
        chk("rst_werf", {31'd0, werf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hit_a", {31'd0, fwd_a_hit}, 32'd0);
        chk("rst_hit_b", {31'd0, fwd_b_hit}, 32'd0);
        chk("rst_data_a", fwd_a_data, 32'd0);
        chk("rst_stall", {31'd0, fwd_stall}, 32'd0);
        mon_en = 1'b1;

        // Directed cases
        send(5'd5, 1'b1, 1'b0, 2'd1, 32'h4, 32'h1234, 0, 0);
        idle();
        force_ra = 7;
        send(5'd7, 1'b1, 1'b0, 2'd2, 32'h8, 32'h0, 2, 32'hDEAD);
        force_ra = -1;
        idle();
        send(5'd9, 1'b1, 1'b1, 2'd2, 32'h100, 32'h55, 3, 32'hBAD);
        idle();
        force_ra = 31;
        send(5'd31, 1'b1, 1'b0, 2'd1, 32'h0, 32'h777, 0, 0);
        idle();
        force_ra = -1;
        force_rb = 2;
        send(5'd1, 1'b1, 1'b0, 2'd1, 32'h0, 32'h11, 0, 0);
        send(5'd2, 1'b1, 1'b0, 2'd1, 32'h0, 32'h22, 0, 0);
        send(5'd3, 1'b1, 1'b0, 2'd1, 32'h0, 32'h33, 0, 0);
        force_rb = -1;
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r = 5'($urandom_range(27, 31));
            we  = ($urandom_range(0, 7) != 0);
            ws  = ($urandom_range(0, 7) == 0);
            sel = 2'($urandom_range(0, 2));
            send(r, we, ws, sel, $urandom, $urandom, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 4) == 0) idle();
        end
        repeat (3) idle();
        chk("queue_drained", expq.size(), 32'd0);
`ifdef WB_STATS_EN
        chk("stat_writes", stat_writes, model_writes);
        chk("stat_load_wait", stat_load_wait, model_waits);
`else
        chk("stat_writes_off", stat_writes, 32'd0);
        chk("stat_load_wait_off", stat_load_wait, 32'd0);
`endif

        // Reset while waiting for a load; later data must be ignored.
        mon_en = 1'b0;
        in_valid = 1'b1; in_rc = 5'd12; in_werf = 1'b1; in_wasel = 1'b0; in_wdsel = 2'd2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("midload_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("postrst_ready", {31'd0, in_ready}, 32'd1);
        chk("postrst_werf", {31'd0, werf}, 32'd0);
        mon_en = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFACE;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        chk("late_rvalid_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) idle();
        chk("late_rvalid_nowrite", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
